// File: rtl/fb_read_arbiter.sv
// Frame-buffer read-port arbiter: scanout always wins; readback bursts fill the
// cycles outside the scanout window, with a 2-cycle tagged return path.
module fb_read_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned WIN_START    = 214,
  parameter int unsigned WIN_END      = 1016,
  parameter int unsigned STARVE_LIMIT = 2048
) (
  input  logic              clk_vga,
  input  logic              reset_n,
  input  logic [10:0]       i_hcnt,
  input  logic              i_vactive,
  input  logic              i_scan_req,
  input  logic [ADDR_W-1:0] i_scan_addr,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_dout,
  output logic              o_scan_valid,
  output logic [DATA_W-1:0] o_scan_data,
  input  logic              i_rb_start,
  input  logic [ADDR_W-1:0] i_rb_addr,
  input  logic [7:0]        i_rb_len,
  output logic              o_rb_busy,
  output logic              o_rb_valid,
  output logic [DATA_W-1:0] o_rb_data,
  output logic              o_rb_done,
  output logic              o_rb_starved
);

  localparam int unsigned REM_W = 9;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_PAUSE, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [STV_W-1:0]    stv_q, stv_d;
  logic                busy_q, busy_d;
  logic                starved_q, starved_d;
  logic                p1_vld_q, p1_vld_d;
  logic                p1_rb_q, p1_rb_d;
  logic                p1_last_q, p1_last_d;
  logic                scan_valid_q, scan_valid_d;
  logic [DATA_W-1:0]   scan_data_q, scan_data_d;
  logic                rb_valid_q, rb_valid_d;
  logic [DATA_W-1:0]   rb_data_q, rb_data_d;
  logic                rb_done_q, rb_done_d;

  logic win_c;
  logic rb_issue_c;
  logic last_ret_c;

  assign win_c = i_vactive && (32'(i_hcnt) >= WIN_START) && (32'(i_hcnt) <= WIN_END);
  // PAUSE may issue in the very cycle the window closes, so both states are eligible
  assign rb_issue_c = ((state_q == S_BURST) || (state_q == S_PAUSE)) && !win_c && !i_scan_req;
  assign last_ret_c = p1_vld_q && p1_rb_q && p1_last_q;

  assign o_mem_en   = i_scan_req || rb_issue_c;
  assign o_mem_addr = i_scan_req ? i_scan_addr : (rb_issue_c ? addr_q : '0);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    stv_d     = stv_q;
    busy_d    = busy_q;
    starved_d = starved_q;
    case (state_q)
      S_IDLE: begin
        if (i_rb_start) begin
          addr_d    = i_rb_addr;
          rem_d     = REM_W'(i_rb_len) + REM_W'(1);
          stv_d     = '0;
          busy_d    = 1'b1;
          starved_d = 1'b0;
          state_d   = S_BURST;
        end
      end
      S_BURST, S_PAUSE: begin
        if (rb_issue_c) begin
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - REM_W'(1);
          stv_d   = '0;
          state_d = (rem_q == REM_W'(1)) ? S_DRAIN : S_BURST;
        end else begin
          state_d = win_c ? S_PAUSE : S_BURST;
          if (stv_q != STV_W'(STARVE_LIMIT)) stv_d = stv_q + STV_W'(1);
          if (stv_d == STV_W'(STARVE_LIMIT)) starved_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (last_ret_c) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Owner tag rides with each grant; data is captured one cycle after the port returns it
  always_comb begin
    p1_vld_d     = o_mem_en;
    p1_rb_d      = rb_issue_c;
    p1_last_d    = rb_issue_c && (rem_q == REM_W'(1));
    scan_valid_d = p1_vld_q && !p1_rb_q;
    rb_valid_d   = p1_vld_q && p1_rb_q;
    rb_done_d    = last_ret_c;
    scan_data_d  = scan_valid_d ? i_mem_dout : scan_data_q;
    rb_data_d    = rb_valid_d ? i_mem_dout : rb_data_q;
  end

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      stv_q        <= '0;
      busy_q       <= 1'b0;
      starved_q    <= 1'b0;
      p1_vld_q     <= 1'b0;
      p1_rb_q      <= 1'b0;
      p1_last_q    <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_data_q  <= '0;
      rb_valid_q   <= 1'b0;
      rb_data_q    <= '0;
      rb_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      stv_q        <= stv_d;
      busy_q       <= busy_d;
      starved_q    <= starved_d;
      p1_vld_q     <= p1_vld_d;
      p1_rb_q      <= p1_rb_d;
      p1_last_q    <= p1_last_d;
      scan_valid_q <= scan_valid_d;
      scan_data_q  <= scan_data_d;
      rb_valid_q   <= rb_valid_d;
      rb_data_q    <= rb_data_d;
      rb_done_q    <= rb_done_d;
    end
  end

  assign o_scan_valid = scan_valid_q;
  assign o_scan_data  = scan_data_q;
  assign o_rb_busy    = busy_q;
  assign o_rb_valid   = rb_valid_q;
  assign o_rb_data    = rb_data_q;
  assign o_rb_done    = rb_done_q;
  assign o_rb_starved = starved_q;

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Directed bench for fb_read_arbiter: a tagged memory model feeds a negedge
// scoreboard of readback issues and returns.
module tb_fb_read_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;

  logic          clk_vga = 1'b0;
  logic          reset_n;
  logic [10:0]   i_hcnt;
  logic          i_vactive;
  logic          i_scan_req;
  logic [AW-1:0] i_scan_addr;
  logic          o_mem_en;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] i_mem_dout;
  logic          o_scan_valid;
  logic [DW-1:0] o_scan_data;
  logic          i_rb_start;
  logic [AW-1:0] i_rb_addr;
  logic [7:0]    i_rb_len;
  logic          o_rb_busy;
  logic          o_rb_valid;
  logic [DW-1:0] o_rb_data;
  logic          o_rb_done;
  logic          o_rb_starved;

  int n_tests = 0;
  int n_fail  = 0;
  logic hrun = 1'b0;

  always #5 clk_vga = ~clk_vga;

  fb_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8)) dut (
    .clk_vga(clk_vga), .reset_n(reset_n), .i_hcnt(i_hcnt), .i_vactive(i_vactive),
    .i_scan_req(i_scan_req), .i_scan_addr(i_scan_addr),
    .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .i_mem_dout(i_mem_dout),
    .o_scan_valid(o_scan_valid), .o_scan_data(o_scan_data),
    .i_rb_start(i_rb_start), .i_rb_addr(i_rb_addr), .i_rb_len(i_rb_len),
    .o_rb_busy(o_rb_busy), .o_rb_valid(o_rb_valid), .o_rb_data(o_rb_data),
    .o_rb_done(o_rb_done), .o_rb_starved(o_rb_starved)
  );

  function automatic logic [63:0] data_of(input logic [15:0] a);
    return {16'hD00D, a, ~a, a ^ 16'h5A5A};
  endfunction

  // Read port: data valid the cycle after the enable
  initial i_mem_dout = '0;
  always @(posedge clk_vga) if (o_mem_en) i_mem_dout <= data_of(o_mem_addr);

  logic [15:0] iss_a[$];
  int          iss_c[$];
  int          iss_h[$];
  logic [63:0] ret_d[$];
  int          done_cnt = 0;
  int          done_idx = 0;
  int          cyc = 0;

  always @(negedge clk_vga) begin
    cyc++;
    if (o_mem_en && !i_scan_req) begin
      iss_a.push_back(o_mem_addr);
      iss_c.push_back(cyc);
      iss_h.push_back(int'(i_hcnt));
    end
    if (o_rb_valid) ret_d.push_back(o_rb_data);
    if (o_rb_done) begin
      done_cnt++;
      done_idx = ret_d.size();
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_vga);
    #1;
    if (hrun) i_hcnt = (i_hcnt == 11'd1055) ? 11'd0 : i_hcnt + 11'd1;
  endtask

  task automatic clr_sb();
    iss_a.delete(); iss_c.delete(); iss_h.delete(); ret_d.delete();
    done_cnt = 0; done_idx = 0;
  endtask

  task automatic start_burst(input logic [15:0] a, input logic [7:0] len);
    clr_sb();
    i_rb_start = 1'b1; i_rb_addr = a; i_rb_len = len;
    tick();
    i_rb_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("done_timeout", 64'(done_cnt), 64'(target));
  endtask

  task automatic check_stream(input string tag, input logic [15:0] base, input int n);
    logic [15:0] a;
    check({tag, "_nissue"}, 64'(iss_a.size()), 64'(n));
    check({tag, "_nret"}, 64'(ret_d.size()), 64'(n));
    check({tag, "_doneidx"}, 64'(done_idx), 64'(n));
    for (int i = 0; i < n && i < iss_a.size() && i < ret_d.size(); i++) begin
      a = base + 16'(i);
      check({tag, "_addr"}, 64'(iss_a[i]), 64'(a));
      check({tag, "_data"}, ret_d[i], data_of(a));
    end
  endtask

  initial begin
    reset_n = 1'b0; i_hcnt = '0; i_vactive = 1'b0; i_scan_req = 1'b0; i_scan_addr = '0;
    i_rb_start = 1'b0; i_rb_addr = '0; i_rb_len = '0;
    tick(); tick();
    check("rst_busy", 64'(o_rb_busy), 0);
    check("rst_rbvalid", 64'(o_rb_valid), 0);
    check("rst_done", 64'(o_rb_done), 0);
    check("rst_starved", 64'(o_rb_starved), 0);
    check("rst_scanvalid", 64'(o_scan_valid), 0);
    check("rst_memen", 64'(o_mem_en), 0);
    reset_n = 1'b1;
    tick();

    // Basic 4-word burst outside the window
    start_burst(16'h0100, 8'd3);
    check("b4_busy", 64'(o_rb_busy), 1);
    wait_done(1, 30);
    check_stream("b4", 16'h0100, 4);
    if (iss_c.size() == 4) check("b4_consec", 64'(iss_c[3] - iss_c[0]), 3);
    check("b4_busy_clr", 64'(o_rb_busy), 0);

    // Address wrap
    start_burst(16'hFFFE, 8'd3);
    wait_done(1, 30);
    check_stream("wrap", 16'hFFFE, 4);

    // Single-word burst, and a start while busy is ignored
    start_burst(16'h0042, 8'd0);
    i_rb_start = 1'b1; i_rb_addr = 16'h0900; i_rb_len = 8'd5;
    tick();
    i_rb_start = 1'b0;
    wait_done(1, 30);
    repeat (6) tick();
    check("one_donecnt", 64'(done_cnt), 1);
    check_stream("one", 16'h0042, 1);

    // Scanout pre-empts a running burst
    start_burst(16'h0200, 8'd7);
    tick();
    i_scan_req = 1'b1; i_scan_addr = 16'h1234;
    #1;
    check("scan_en", 64'(o_mem_en), 1);
    check("scan_addr", 64'(o_mem_addr), 64'h1234);
    tick();
    i_scan_req = 1'b0;
    check("scan_v1", 64'(o_scan_valid), 0);
    tick();
    check("scan_v2", 64'(o_scan_valid), 1);
    check("scan_data", o_scan_data, data_of(16'h1234));
    wait_done(1, 40);
    check_stream("intl", 16'h0200, 8);

    // Starvation flag after 8 blocked cycles, sticky until next start
    start_burst(16'h0300, 8'd3);
    i_scan_req = 1'b1; i_scan_addr = 16'h0777;
    repeat (7) tick();
    check("starve_7", 64'(o_rb_starved), 0);
    tick();
    check("starve_8", 64'(o_rb_starved), 1);
    tick(); tick();
    i_scan_req = 1'b0;
    wait_done(1, 30);
    check_stream("stv", 16'h0300, 4);
    check("starve_sticky", 64'(o_rb_starved), 1);
    start_burst(16'h0310, 8'd0);
    check("starve_clr", 64'(o_rb_starved), 0);
    wait_done(1, 30);

    // Window pause: issues stop at 214 and resume at 1017
    i_vactive = 1'b1; hrun = 1'b1; i_hcnt = 11'd205;
    start_burst(16'h0600, 8'd15);
    wait_done(1, 2000);
    check_stream("win", 16'h0600, 16);
    if (iss_h.size() == 16) begin
      check("win_h0", 64'(iss_h[0]), 206);
      check("win_h7", 64'(iss_h[7]), 213);
      check("win_h8", 64'(iss_h[8]), 1017);
      check("win_h15", 64'(iss_h[15]), 1024);
    end
    i_hcnt = 11'd1010;
    start_burst(16'h0700, 8'd15);
    wait_done(1, 200);
    check_stream("win2", 16'h0700, 16);
    if (iss_h.size() == 16) begin
      check("win2_h0", 64'(iss_h[0]), 1017);
      check("win2_h15", 64'(iss_h[15]), 1032);
    end
    i_vactive = 1'b0; hrun = 1'b0;

    // Reset mid-burst abandons in-flight data
    start_burst(16'h0400, 8'd7);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    check("mrst_busy", 64'(o_rb_busy), 0);
    check("mrst_rbvalid", 64'(o_rb_valid), 0);
    check("mrst_rbdata", o_rb_data, 0);
    check("mrst_starved", 64'(o_rb_starved), 0);
    check("mrst_memen", 64'(o_mem_en), 0);
    clr_sb();
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("mrst_noret", 64'(ret_d.size()), 0);
    check("mrst_nodone", 64'(done_cnt), 0);
    start_burst(16'h0500, 8'd1);
    wait_done(1, 30);
    check_stream("post", 16'h0500, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
